// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: state encoding and counter sizing helper.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned result;
    result = 1;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Binary index to one-hot conversion, active-high; polarity is the caller's concern.
module onehot_dec #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]      idx_i,
  output logic [(2**N)-1:0] onehot_o
);

  localparam int unsigned OUTW = 2 ** N;

  always_comb begin
    onehot_o = OUTW'(1) << idx_i;
  end

endmodule

// File: rtl/scan_decoder.sv
// Decoder with hold and auto-scan modes: drives one active output selected by a
// registered index, which either holds a loaded value or steps after a dwell time.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned DWELL      = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      sel,
  output logic [(2**N)-1:0] D,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned OUTW = 2 ** N;
  localparam int unsigned DW   = clog2_min1(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST   = '1;

  state_t         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic           wrap_q, wrap_d;
  logic [OUTW-1:0] dec_c;
  logic [OUTW-1:0] active_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

  // Priority: disable, then load, then mode change, then dwell advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      dwell_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mode) begin
            state_d = SCAN;
            dwell_d = '0;
            if (load) idx_d = sel;
          end else if (load) begin
            state_d = HOLD;
            idx_d   = sel;
          end
        end
        HOLD: begin
          if (load) idx_d = sel;
          if (mode) begin
            state_d = SCAN;
            dwell_d = '0;
          end
        end
        SCAN: begin
          if (load) begin
            idx_d   = sel;
            dwell_d = '0;
          end
          if (!mode) begin
            state_d = HOLD;
            dwell_d = '0;
          end else if (!load) begin
            if (dwell_q == DWELL_LAST) begin
              dwell_d = '0;
              idx_d   = idx_q + N'(1);
              wrap_d  = (idx_q == IDX_LAST);
            end else begin
              dwell_d = dwell_q + DW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          dwell_d = '0;
        end
      endcase
    end
  end

  onehot_dec #(.N(N)) u_dec (
    .idx_i    (idx_q),
    .onehot_o (dec_c)
  );

  // Output follows registered state only, so reset forces it inactive at once.
  always_comb begin
    active_c = (state_q == IDLE) ? '0 : dec_c;
    D        = ACTIVE_LOW ? ~active_c : active_c;
  end

  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
